// File: rtl/superhub_switch.sv
// superhub_switch: 4x4 super-hub crossbar stage above the cluster mini-networks.
// Each cluster input is buffered in its own FIFO, routed by the destination
// cluster field [19:18], and each output arbitrates round-robin under credit
// flow control towards the cluster hub's down-from-SH buffer.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   up_data      4 x 20-bit input flits, cluster k at [20k+19:20k]
//   up_valid     per-input flit-present strobe
//   up_co        per-input one-cycle credit return (one FIFO slot freed)
//   dn_data      4 x 20-bit output flits, same packing as up_data
//   dn_valid     per-output single-cycle flit strobe
//   dn_ci        per-output credit return pulse from the cluster hub
//   err_overflow sticky: flit arrived on a full input FIFO
//   err_credit   sticky: credit returned with the counter already full
module superhub_switch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DN_CREDITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] up_data,
  input  logic [3:0]  up_valid,
  output logic [3:0]  up_co,
  output logic [79:0] dn_data,
  output logic [3:0]  dn_valid,
  input  logic [3:0]  dn_ci,
  output logic [3:0]  err_overflow,
  output logic [3:0]  err_credit
);

  localparam int unsigned NP = 4;
  localparam int unsigned FW = 20;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned KW = $clog2(DN_CREDITS + 1);

  logic [FW-1:0] mem [NP][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [NP];
  logic [PW-1:0] rd_ptr [NP];
  logic [CW-1:0] cnt [NP];
  logic [KW-1:0] credit [NP];
  logic [1:0]    rr [NP];

  logic [FW-1:0] head [NP];
  logic [1:0]    head_dst [NP];
  logic [NP-1:0] nonempty;
  logic [NP-1:0] wr_en;
  logic [NP-1:0] drop;
  logic [NP-1:0] pop;
  logic [NP-1:0] pop_q;
  logic [NP-1:0] gnt_valid;
  logic [1:0]    gnt_src [NP];

  // FIFO head view and write acceptance; a full FIFO still accepts when it pops.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      head[i]     = mem[i][rd_ptr[i]];
      head_dst[i] = head[i][19:18];
      nonempty[i] = (cnt[i] != '0);
      wr_en[i]    = up_valid[i] && ((cnt[i] != CW'(FIFO_DEPTH)) || pop[i]);
      drop[i]     = up_valid[i] && !wr_en[i];
    end
  end

  // Per-output round-robin arbiter starting at rr[j], gated by credit.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    gnt_valid = '0;
    pop       = '0;
    for (int j = 0; j < NP; j++) begin
      gnt_src[j] = '0;
    end
    for (int j = 0; j < NP; j++) begin
      if (credit[j] != '0) begin
        for (int off = 0; off < NP; off++) begin
          idx = 2'(rr[j] + 2'(off));
          if (!gnt_valid[j] && nonempty[idx] && (head_dst[idx] == 2'(j))) begin
            gnt_valid[j] = 1'b1;
            gnt_src[j]   = idx;
          end
        end
      end
    end
    for (int j = 0; j < NP; j++) begin
      if (gnt_valid[j]) begin
        pop[gnt_src[j]] = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i]] <= up_data[i*FW +: FW];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (wr_en[i]) begin
          wr_ptr[i] <= (wr_ptr[i] == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= (rd_ptr[i] == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr[i] + 1'b1;
        end
        case ({wr_en[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Output registers, arbitration pointers and credit counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dn_data    <= '0;
      dn_valid   <= '0;
      err_credit <= '0;
      for (int j = 0; j < NP; j++) begin
        rr[j]     <= '0;
        credit[j] <= KW'(DN_CREDITS);
      end
    end else begin
      dn_valid <= gnt_valid;
      for (int j = 0; j < NP; j++) begin
        if (gnt_valid[j]) begin
          dn_data[j*FW +: FW] <= head[gnt_src[j]];
          rr[j]               <= 2'(gnt_src[j] + 2'd1);
        end
        // Grant and returned credit in the same cycle cancel out.
        case ({gnt_valid[j], dn_ci[j]})
          2'b10:   credit[j] <= credit[j] - 1'b1;
          2'b01:   if (credit[j] != KW'(DN_CREDITS)) credit[j] <= credit[j] + 1'b1;
          default: credit[j] <= credit[j];
        endcase
        if (dn_ci[j] && (credit[j] == KW'(DN_CREDITS))) begin
          err_credit[j] <= 1'b1;
        end
      end
    end
  end

  // Upstream credit return lags the pop by one cycle; overflow flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_q        <= '0;
      up_co        <= '0;
      err_overflow <= '0;
    end else begin
      pop_q        <= pop;
      up_co        <= pop_q;
      err_overflow <= err_overflow | drop;
    end
  end

endmodule

// File: tb/tb_superhub_switch.sv
// tb_superhub_switch: directed self-checking bench for superhub_switch.
module tb_superhub_switch;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] up_data;
  logic [3:0]  up_valid;
  logic [3:0]  up_co;
  logic [79:0] dn_data;
  logic [3:0]  dn_valid;
  logic [3:0]  dn_ci;
  logic [3:0]  err_overflow;
  logic [3:0]  err_credit;

  int checks = 0;
  int errors = 0;

  superhub_switch #(.FIFO_DEPTH(4), .DN_CREDITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .up_data      (up_data),
    .up_valid     (up_valid),
    .up_co        (up_co),
    .dn_data      (dn_data),
    .dn_valid     (dn_valid),
    .dn_ci        (dn_ci),
    .err_overflow (err_overflow),
    .err_credit   (err_credit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b0;
    up_data  = '0;
    up_valid = '0;
    dn_ci    = '0;

    // Reset held with random activity: every output stays at zero.
    for (int c = 0; c < 4; c++) begin
      up_data  = 80'({$urandom(), $urandom(), $urandom()});
      up_valid = 4'($urandom());
      dn_ci    = 4'($urandom());
      tick();
      chk("rst_ctl", 80'({up_co, dn_valid, err_overflow, err_credit}), 80'h0);
      chk("rst_data", dn_data, 80'h0);
    end
    up_data  = '0;
    up_valid = '0;
    dn_ci    = '0;
    rst      = 1'b1;
    tick();
    chk("rel_ctl", 80'({up_co, dn_valid, err_overflow, err_credit}), 80'h0);

    // Credit exhaustion: six flits input 0 -> output 3, only four credits.
    for (int k = 1; k <= 6; k++) begin
      up_data  = 80'(20'hC0000 | 20'(k));
      up_valid = 4'b0001;
      tick();
      if (k >= 2 && k <= 5) begin
        chk("cx_valid", 80'(dn_valid), 80'h8);
        chk("cx_data", 80'(dn_data[79:60]), 80'(20'hC0000 | 20'(k - 1)));
      end else begin
        chk("cx_valid_idle", 80'(dn_valid), 80'h0);
      end
    end
    up_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("cx_stall", 80'(dn_valid), 80'h0);
    end
    for (int p = 5; p <= 6; p++) begin
      dn_ci = 4'b1000;
      tick();
      dn_ci = '0;
      chk("cx_ci_edge", 80'(dn_valid), 80'h0);
      tick();
      chk("cx_resume_valid", 80'(dn_valid), 80'h8);
      chk("cx_resume_data", 80'(dn_data[79:60]), 80'(20'hC0000 | 20'(p)));
      tick();
      chk("cx_one_per_credit", 80'(dn_valid), 80'h0);
    end
    chk("cx_err_credit", 80'(err_credit), 80'h0);
    dn_ci = 4'b1000;
    for (int c = 0; c < 4; c++) tick();
    dn_ci = '0;
    chk("cx_refill_noerr", 80'(err_credit), 80'h0);
    dn_ci = 4'b1000;
    tick();
    dn_ci = '0;
    chk("cx_sat_err", 80'(err_credit), 80'h8);

    // Single flit input 0 -> output 2.
    up_data  = 80'h8ABCD;
    up_valid = 4'b0001;
    tick();
    up_valid = '0;
    chk("sf_n_valid", 80'(dn_valid), 80'h0);
    chk("sf_n_co", 80'(up_co), 80'h0);
    tick();
    chk("sf_n1_valid", 80'(dn_valid), 80'h4);
    chk("sf_n1_data", 80'(dn_data[59:40]), 80'h8ABCD);
    chk("sf_n1_co", 80'(up_co), 80'h0);
    tick();
    chk("sf_n2_valid", 80'(dn_valid), 80'h0);
    chk("sf_n2_co", 80'(up_co), 80'h1);
    chk("sf_hold_data", 80'(dn_data[59:40]), 80'h8ABCD);
    tick();
    chk("sf_n3_co", 80'(up_co), 80'h0);
    dn_ci = 4'b0100;
    tick();
    dn_ci = '0;

    // Contention: all inputs to output 1, two waves, each starting at source 0.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        up_data[i*20 +: 20] = 20'(32'h40000 | (w << 8) | i);
      end
      up_valid = 4'b1111;
      tick();
      up_valid = '0;
      chk("ct_write", 80'(dn_valid), 80'h0);
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("ct_valid", 80'(dn_valid), 80'h2);
        chk("ct_order", 80'(dn_data[39:20]), 80'(20'(32'h40000 | (w << 8) | i)));
      end
      tick();
      chk("ct_done", 80'(dn_valid), 80'h0);
      dn_ci = 4'b0010;
      for (int c = 0; c < 4; c++) tick();
      dn_ci = '0;
    end
    chk("ct_err_sticky", 80'(err_credit), 80'h8);

    // Drain output 2 credit with self-returning flits from input 2.
    up_data = '0;
    for (int k = 0; k < 5; k++) begin
      up_data[59:40] = 20'(32'h80200 | k);
      up_valid = (k < 4) ? 4'b0100 : 4'b0000;
      tick();
      if (k >= 1) begin
        chk("self_valid", 80'(dn_valid), 80'h4);
        chk("self_data", 80'(dn_data[59:40]), 80'(20'(32'h80200 | (k - 1))));
      end
    end
    up_valid = '0;

    // Overflow: five flits into input 1 toward blocked output 2.
    up_data = '0;
    for (int k = 0; k < 5; k++) begin
      up_data[39:20] = 20'(32'h80100 | k);
      up_valid = 4'b0010;
      tick();
      chk("ov_blocked", 80'(dn_valid), 80'h0);
      chk("ov_flag", 80'(err_overflow), (k == 4) ? 80'h2 : 80'h0);
    end
    up_valid = '0;
    tick();
    chk("ov_sticky", 80'(err_overflow), 80'h2);
    dn_ci = 4'b0100;
    tick();
    dn_ci = '0;
    tick();
    chk("ov_drain_valid", 80'(dn_valid), 80'h4);
    chk("ov_drain_data", 80'(dn_data[59:40]), 80'h80100);
    tick();
    chk("ov_drain_stop", 80'(dn_valid), 80'h0);
    chk("ov_drain_co", 80'(up_co), 80'h2);
    tick();
    chk("ov_co_end", 80'(up_co), 80'h0);

    // Reset mid-flight with three flits still buffered in input 1.
    rst = 1'b0;
    #1;
    chk("mf_async_ctl", 80'({up_co, dn_valid, err_overflow, err_credit}), 80'h0);
    chk("mf_async_data", dn_data, 80'h0);
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mf_no_valid", 80'(dn_valid), 80'h0);
      chk("mf_no_co", 80'(up_co), 80'h0);
    end

    // After reset: credits reloaded to exactly four on output 2.
    up_data = '0;
    for (int k = 0; k < 6; k++) begin
      up_data[79:60] = 20'(32'h80300 | k);
      up_valid = (k < 5) ? 4'b1000 : 4'b0000;
      tick();
      if (k >= 1 && k <= 4) begin
        chk("pr_valid", 80'(dn_valid), 80'h4);
        chk("pr_data", 80'(dn_data[59:40]), 80'(20'(32'h80300 | (k - 1))));
      end else if (k == 5) begin
        chk("pr_fifth_held", 80'(dn_valid), 80'h0);
      end
    end
    up_valid = '0;
    tick();
    chk("pr_stall", 80'(dn_valid), 80'h0);
    chk("pr_errs", 80'({err_overflow, err_credit}), 80'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/superhub_switch.md
Name: superhub_switch

Overview:
- Top-level super-hub stage sitting directly above the four cluster mini-networks.
- Consumes each cluster hub's up-to-SH stream (20-bit flit, valid, credit) and feeds each cluster hub's down-from-SH stream.
- Buffers per-input flits, routes each flit by destination cluster field, and arbitrates each output round-robin under credit flow control.

Parameters:
- FIFO_DEPTH, 4, flits buffered per input port; also the number of credits the upstream cluster hub holds for this input.
- DN_CREDITS, 4, initial credit count per output, equal to the cluster hub's down-from-SH buffer depth.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low: asserted at 0, released at 1.
- up_data  input  80  four 20-bit flits; cluster k occupies bits [20k+19:20k].
- up_valid  input  4  bit k: flit present on cluster k input this cycle.
- up_co  output  4  bit k: one-cycle credit-return pulse to cluster k (one slot freed).
- dn_data  output  80  four 20-bit flits to cluster hubs, same packing as up_data.
- dn_valid  output  4  bit k: dn_data slice k valid this cycle.
- dn_ci  input  4  bit k: one-cycle credit-return pulse from cluster k hub.
- err_overflow  output  4  sticky; bit k set when a flit arrives on a full input FIFO k.
- err_credit  output  4  sticky; bit k set when dn_ci[k] arrives with the credit counter already at DN_CREDITS.

Behaviour:
- Flit format: [19:18] destination cluster, [17:16] destination local node, [15:0] payload. Single-flit packets.
- Routing uses [19:18] only. Flits are forwarded unmodified. A flit whose destination equals its source cluster is returned to that cluster.
- Reset (rst=0, asynchronous):
  - FIFOs emptied.
  - All outputs 0: dn_data, dn_valid, up_co, err_*.
  - Credit counters loaded with DN_CREDITS.
  - Round-robin pointers set to 0.
  - Reset mid-operation discards all buffered and in-flight flits. No credit pulses are emitted for them.
- Input side:
  - up_valid[k]=1 with FIFO k not full: flit written at that edge.
  - FIFO k full: flit dropped, err_overflow[k] set. FIFO contents are unchanged.
  - A write and a pop on the same cycle are both allowed when the FIFO is full; the incoming flit is accepted.
- Credit return: one cycle after FIFO k pops a flit, up_co[k]=1 for exactly one cycle. One pulse per popped flit.
- Arbitration, per output j, evaluated every cycle:
  - Requesters are inputs whose FIFO is non-empty and whose head destination is j.
  - A grant is made only if credit[j] > 0.
  - Round-robin: search starts at rr[j]. After a grant to input i, rr[j] becomes (i+1) mod 4. With no grant, rr[j] holds.
  - Each input head targets exactly one output, so an input receives at most one grant per cycle. Head-of-line blocking is accepted.
- Output register: a granted flit is popped and registered into dn_data slice j with dn_valid[j]=1 on the next edge. dn_valid[j] is a single-cycle pulse per flit. dn_data holds its last value when dn_valid[j]=0.
- Latency: a flit sampled on up_valid at edge N appears on dn_valid at edge N+1 at minimum (empty FIFO, credit available, no contention).
- Throughput: one flit per output per cycle; four flits per cycle aggregate.
- Credit counter per output, width clog2(DN_CREDITS+1):
  - Decrement on grant; increment on dn_ci[j]; unchanged when both occur in the same cycle.
  - Saturates at DN_CREDITS; dn_ci at saturation sets err_credit[j].
  - Never decrements below 0, since no grant is made at 0.
- Sticky error bits clear only on reset.

Test Plan:
- Reset check: hold rst=0, drive random inputs -> all outputs 0. Release rst; internal credit=4 is confirmed by 4 back-to-back grants.
- Single flit: up_data slice 0 = 20'h8ABCD, up_valid=4'b0001 at edge N -> dn_valid[2]=1 with dn_data slice 2 = 20'h8ABCD at edge N+1; up_co[0]=1 at edge N+2 only.
- Contention: all four inputs send a flit with dst=1 in the same cycle, ample credit -> dn_valid[1] on four consecutive cycles carrying sources 0,1,2,3 in that order. A second identical wave starts at source 0 again.
- Credit exhaustion: input 0 sends 6 flits to dst=3, with dn_ci held 0 -> exactly 4 delivered, then stall. Pulse dn_ci[3] twice -> remaining 2 delivered, one per credit. err_credit stays 0.
- Overflow: block output 2 (credit 0), send 5 flits on input 1 to dst 2 -> first 4 buffered, fifth dropped, err_overflow=4'b0010 and sticky.
- Reset mid-flight: assert rst with 3 flits buffered -> dn_valid never asserts for them, no up_co pulses. After release the block operates normally with credits reloaded to 4.
